sound_comm_latch: RTL and testbench
===================================

SOUND_COMM_LATCH -- requirements
Module: sound_comm_latch

Interface
REQ-001 SHALL have parameter DATA_W, default 8, latch and bus width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, sound-to-main FIFO entries (power of two, >=2); used only when SOUND_COMM_FIFO_EN is defined.
REQ-003 SHALL have ports (clock and reset first):
- clk  in  1  system clock; all strobes are synchronous to it.
- rst_l  in  1  asynchronous active-low reset.
- WR68k_l  in  1  sound-CPU write strobe to main mailbox, from sound address decoder, active low.
- RD68k_l  in  1  sound-CPU read strobe of main-to-sound mailbox, active low.
- snd_data_in  in  DATA_W  sound-CPU write data.
- snd_data_out  out  DATA_W  main-to-sound mailbox contents.
- main_wr_l  in  1  main-CPU write strobe to sound mailbox, active low.
- main_rd_l  in  1  main-CPU read strobe of sound-to-main mailbox, active low.
- main_data_in  in  DATA_W  main-CPU write data.
- main_data_out  out  DATA_W  sound-to-main mailbox head.
- snd_pending  out  1  main-to-sound byte unread.
- main_pending  out  1  sound-to-main byte(s) unread.
- snd_irq_l  out  1  sound-CPU interrupt, active low.
- main_irq_l  out  1  main-CPU interrupt, active low.
- snd_ovr  out  1  sticky main-to-sound overrun.
- main_ovr  out  1  sticky sound-to-main overrun.

Function
REQ-004 SHALL register each strobe every clk; an access event SHALL be the strobe's deassertion (registered value 0, current value 1), producing exactly one event per strobe pulse regardless of pulse length.
REQ-005 SHALL capture write data on the write event cycle's clk edge, sampling the data input in that cycle.
REQ-006 Main write event SHALL load the main-to-sound latch and set snd_pending on the same edge.
REQ-007 Sound read event (RD68k_l) SHALL clear snd_pending; snd_data_out SHALL continuously drive the latch and SHALL not change on read.
REQ-008 Main write event while snd_pending=1 and no same-cycle sound read event SHALL overwrite the latch and set snd_ovr.
REQ-009 Same-cycle main write and sound read events SHALL load the new byte, leave snd_pending=1, and not set snd_ovr.
REQ-010 snd_irq_l SHALL be a register equal to ~snd_pending of the previous cycle (one-cycle latency); main_irq_l likewise from main_pending.
REQ-011 snd_ovr SHALL clear on a sound read event; main_ovr SHALL clear on a main read event; set has priority over clear in the same cycle.
REQ-012 Without SOUND_COMM_FIFO_EN, the sound-to-main direction SHALL mirror REQ-006..REQ-009 (WR68k_l loads, main_rd_l clears main_pending, main_ovr on overwrite).
REQ-013 With SOUND_COMM_FIFO_EN, sound-to-main SHALL be a FIFO: WR68k_l event pushes, main_rd_l event pops, main_pending = not empty, main_data_out = head entry when non-empty, else last popped byte.
REQ-014 FIFO push when full without same-cycle pop SHALL drop the byte, leave contents unchanged, and set main_ovr.
REQ-015 FIFO push and pop in the same cycle SHALL both occur at any fill level; when empty, only the push takes effect.
REQ-016 Pop when empty SHALL be ignored with no pointer change.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an occupancy count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-018 rst_l low SHALL immediately clear latches/FIFO to 0x00, pointers and count to 0, pending and ovr flags to 0, irq outputs to 1, registered strobes to 1.
REQ-019 A strobe low while reset is released SHALL not generate an event until it is seen high after being low post-reset.

Configuration
REQ-020 Macro SOUND_COMM_FIFO_EN SHALL, when defined, compile the FIFO of REQ-013..REQ-017; when undefined, a single latch (REQ-012) and FIFO_DEPTH unused.

Verification
REQ-021 Main writes 0x5A, sound reads -> snd_data_out=0x5A, snd_pending 1 then 0, snd_irq_l low one cycle after set, high one cycle after clear.
REQ-022 Two main writes 0x11, 0x22 without read -> snd_data_out=0x22, snd_ovr=1; sound read clears both flags.
REQ-023 Same-cycle main write 0x33 and sound read events with snd_pending=1 -> snd_pending=1, snd_ovr=0, data 0x33.
REQ-024 FIFO_EN, depth 4: push 0x01..0x05 -> 0x05 dropped, main_ovr=1; four pops return 0x01..0x04, then main_pending=0, main_data_out=0x04.
REQ-025 FIFO_EN full: same-cycle push 0x09 and pop -> pop 0x01, count stays 4, main_ovr unchanged.
REQ-026 rst_l asserted with 2 FIFO entries and WR68k_l held low -> all flags 0, irqs 1; releasing WR68k_l after reset produces no push.

Source files
------------

// File: rtl/sound_comm_latch.sv
// Bidirectional sound/main CPU mailbox with strobe-release event detection.
// Define SOUND_COMM_FIFO_EN to turn the sound-to-main latch into a FIFO_DEPTH-entry FIFO.
module sound_comm_latch #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              WR68k_l,
    input  logic              RD68k_l,
    input  logic [DATA_W-1:0] snd_data_in,
    output logic [DATA_W-1:0] snd_data_out,
    input  logic              main_wr_l,
    input  logic              main_rd_l,
    input  logic [DATA_W-1:0] main_data_in,
    output logic [DATA_W-1:0] main_data_out,
    output logic              snd_pending,
    output logic              main_pending,
    output logic              snd_irq_l,
    output logic              main_irq_l,
    output logic              snd_ovr,
    output logic              main_ovr
);

    localparam int S_SW = 0;  // WR68k_l
    localparam int S_SR = 1;  // RD68k_l
    localparam int S_MW = 2;  // main_wr_l
    localparam int S_MR = 3;  // main_rd_l

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic [3:0] w_strb;
    logic [3:0] r_strb;
    logic [3:0] r_arm;
    logic [3:0] w_ev;

    assign w_strb = {main_rd_l, main_wr_l, RD68k_l, WR68k_l};
    // A strobe only arms once it has been seen high after reset, so a strobe
    // held low across reset cannot produce a spurious release event.
    assign w_ev   = r_arm & ~r_strb & w_strb;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_strb <= '1;
            r_arm  <= '0;
        end else begin
            r_strb <= w_strb;
            r_arm  <= r_arm | w_strb;
        end
    end

    logic [DATA_W-1:0] r_snd_latch;
    logic              r_snd_pend;
    logic              r_snd_ovr;
    logic              r_snd_irq_l;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_snd_latch <= '0;
            r_snd_pend  <= 1'b0;
            r_snd_ovr   <= 1'b0;
            r_snd_irq_l <= 1'b1;
        end else begin
            if (w_ev[S_MW]) begin
                r_snd_latch <= main_data_in;
                r_snd_pend  <= 1'b1;
            end else if (w_ev[S_SR]) begin
                r_snd_pend  <= 1'b0;
            end
            if (w_ev[S_MW] && r_snd_pend && !w_ev[S_SR])
                r_snd_ovr <= 1'b1;
            else if (w_ev[S_SR])
                r_snd_ovr <= 1'b0;
            r_snd_irq_l <= ~r_snd_pend;
        end
    end

    assign snd_data_out = r_snd_latch;
    assign snd_pending  = r_snd_pend;
    assign snd_ovr      = r_snd_ovr;
    assign snd_irq_l    = r_snd_irq_l;

    logic w_main_pend;
    logic r_main_irq_l;

`ifdef SOUND_COMM_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LP_FULL = FIFO_DEPTH[AW:0];

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_cnt;
    logic [DATA_W-1:0] r_last;
    logic              r_main_ovr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;

    assign w_full  = (r_cnt == LP_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_pop   = w_ev[S_MR] && !w_empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign w_push  = w_ev[S_SW] && (!w_full || w_ev[S_MR]);
    assign w_drop  = w_ev[S_SW] && w_full && !w_ev[S_MR];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_main_ovr <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= snd_data_in;
                r_wp        <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_last <= r_mem[r_rp];
                r_rp   <= r_rp + AW'(1);
            end
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (w_drop)
                r_main_ovr <= 1'b1;
            else if (w_ev[S_MR])
                r_main_ovr <= 1'b0;
        end
    end

    assign w_main_pend   = !w_empty;
    assign main_data_out = w_empty ? r_last : r_mem[r_rp];
    assign main_ovr      = r_main_ovr;
`else
    logic [DATA_W-1:0] r_main_latch;
    logic              r_main_pend;
    logic              r_main_ovr;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_main_latch <= '0;
            r_main_pend  <= 1'b0;
            r_main_ovr   <= 1'b0;
        end else begin
            if (w_ev[S_SW]) begin
                r_main_latch <= snd_data_in;
                r_main_pend  <= 1'b1;
            end else if (w_ev[S_MR]) begin
                r_main_pend  <= 1'b0;
            end
            if (w_ev[S_SW] && r_main_pend && !w_ev[S_MR])
                r_main_ovr <= 1'b1;
            else if (w_ev[S_MR])
                r_main_ovr <= 1'b0;
        end
    end

    assign w_main_pend   = r_main_pend;
    assign main_data_out = r_main_latch;
    assign main_ovr      = r_main_ovr;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_main_irq_l <= 1'b1;
        else        r_main_irq_l <= ~w_main_pend;
    end

    assign main_pending = w_main_pend;
    assign main_irq_l   = r_main_irq_l;

endmodule

// File: tb/tb_sound_comm_latch.sv
// Directed bench for sound_comm_latch: spec-level mailbox/FIFO model checked every
// negedge, plus literal expectations for the key scenarios.
module tb_sound_comm_latch;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          WR68k_l, RD68k_l, main_wr_l, main_rd_l;
    logic [DW-1:0] snd_data_in, main_data_in;
    logic [DW-1:0] snd_data_out, main_data_out;
    logic          snd_pending, main_pending, snd_irq_l, main_irq_l, snd_ovr, main_ovr;

    sound_comm_latch #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l),
        .WR68k_l(WR68k_l), .RD68k_l(RD68k_l), .snd_data_in(snd_data_in),
        .snd_data_out(snd_data_out),
        .main_wr_l(main_wr_l), .main_rd_l(main_rd_l), .main_data_in(main_data_in),
        .main_data_out(main_data_out),
        .snd_pending(snd_pending), .main_pending(main_pending),
        .snd_irq_l(snd_irq_l), .main_irq_l(main_irq_l),
        .snd_ovr(snd_ovr), .main_ovr(main_ovr)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Strobe index: 0 WR68k_l, 1 RD68k_l, 2 main_wr_l, 3 main_rd_l.
    bit            m_seen_hi [4];
    bit            m_was_lo  [4];
    logic [DW-1:0] m_snd_data, m_main_data, m_last;
    bit            m_snd_pend, m_main_pend, m_snd_ovr, m_main_ovr, m_snd_irq, m_main_irq;
    logic [DW-1:0] m_q [$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_seen_hi[i] = 0;
            m_was_lo[i]  = 0;
        end
        m_snd_data = '0; m_main_data = '0; m_last = '0;
        m_snd_pend = 0; m_main_pend = 0; m_snd_ovr = 0; m_main_ovr = 0;
        m_snd_irq = 1; m_main_irq = 1;
        m_q.delete();
    endtask

    function automatic bit model_pending_main();
`ifdef SOUND_COMM_FIFO_EN
        return m_q.size() > 0;
`else
        return m_main_pend;
`endif
    endfunction

    function automatic logic [DW-1:0] model_main_out();
`ifdef SOUND_COMM_FIFO_EN
        return (m_q.size() > 0) ? m_q[0] : m_last;
`else
        return m_main_data;
`endif
    endfunction

    // Advance by one clock edge using the inputs that edge will see.
    task automatic model_step();
        bit cur [4];
        bit ev  [4];
        bit sp, mp;
        cur[0] = WR68k_l; cur[1] = RD68k_l; cur[2] = main_wr_l; cur[3] = main_rd_l;
        for (int i = 0; i < 4; i++) begin
            // A release counts only if the strobe was low after having been high post-reset.
            ev[i] = cur[i] && m_was_lo[i];
            if (cur[i]) begin
                m_seen_hi[i] = 1;
                m_was_lo[i]  = 0;
            end else if (m_seen_hi[i]) begin
                m_was_lo[i]  = 1;
            end
        end
        sp = m_snd_pend;
        mp = model_pending_main();
        m_snd_irq  = !sp;
        m_main_irq = !mp;
        if (ev[2]) begin
            if (sp && !ev[1]) m_snd_ovr = 1;
            else if (ev[1])   m_snd_ovr = 0;
            m_snd_data = main_data_in;
            m_snd_pend = 1;
        end else if (ev[1]) begin
            m_snd_pend = 0;
            m_snd_ovr  = 0;
        end
`ifdef SOUND_COMM_FIFO_EN
        begin
            bit full;
            full = (m_q.size() == DEPTH);
            if (ev[3] && m_q.size() > 0) m_last = m_q.pop_front();
            if (ev[0] && full && !ev[3]) m_main_ovr = 1;
            else begin
                if (ev[0]) m_q.push_back(snd_data_in);
                if (ev[3]) m_main_ovr = 0;
            end
        end
`else
        if (ev[0]) begin
            if (mp && !ev[3]) m_main_ovr = 1;
            else if (ev[3])   m_main_ovr = 0;
            m_main_data = snd_data_in;
            m_main_pend = 1;
        end else if (ev[3]) begin
            m_main_pend = 0;
            m_main_ovr  = 0;
        end
`endif
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst_l) model_reset();
            check("snd_data_out",  snd_data_out,  m_snd_data);
            check("snd_pending",   snd_pending,   m_snd_pend);
            check("snd_ovr",       snd_ovr,       m_snd_ovr);
            check("snd_irq_l",     snd_irq_l,     m_snd_irq);
            check("main_data_out", main_data_out, model_main_out());
            check("main_pending",  main_pending,  model_pending_main());
            check("main_ovr",      main_ovr,      m_main_ovr);
            check("main_irq_l",    main_irq_l,    m_main_irq);
            if (rst_l) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pull selected strobes low for len cycles and release together; returns
    // just after the edge on which the release events happen.
    task automatic pulse(input bit sw, input bit sr, input bit mw, input bit mr,
                         input logic [DW-1:0] sd, input logic [DW-1:0] md, input int len);
        snd_data_in  = sd;
        main_data_in = md;
        if (sw) WR68k_l   = 1'b0;
        if (sr) RD68k_l   = 1'b0;
        if (mw) main_wr_l = 1'b0;
        if (mr) main_rd_l = 1'b0;
        step(len);
        WR68k_l = 1'b1; RD68k_l = 1'b1; main_wr_l = 1'b1; main_rd_l = 1'b1;
        step(1);
    endtask

    initial begin
        rst_l = 1'b0;
        WR68k_l = 1'b1; RD68k_l = 1'b1; main_wr_l = 1'b1; main_rd_l = 1'b1;
        snd_data_in = '0; main_data_in = '0;
        step(3);
        check("rst_irq_l",   {snd_irq_l, main_irq_l}, 2'b11);
        check("rst_flags",   {snd_pending, main_pending, snd_ovr, main_ovr}, 4'b0000);
        rst_l = 1'b1;
        step(2);

        // Main writes 0x5A, sound reads it
        pulse(0, 0, 1, 0, 8'h00, 8'h5A, 2);
        check("w5a_data",  snd_data_out, 8'h5A);
        check("w5a_pend",  snd_pending, 1'b1);
        check("w5a_irq0",  snd_irq_l, 1'b1);
        step(1);
        check("w5a_irq1",  snd_irq_l, 1'b0);
        pulse(0, 1, 0, 0, 8'h00, 8'h00, 3);
        check("r5a_pend",  snd_pending, 1'b0);
        check("r5a_data",  snd_data_out, 8'h5A);
        check("r5a_irq0",  snd_irq_l, 1'b0);
        step(1);
        check("r5a_irq1",  snd_irq_l, 1'b1);

        // Overrun on second unread write
        pulse(0, 0, 1, 0, 8'h00, 8'h11, 1);
        pulse(0, 0, 1, 0, 8'h00, 8'h22, 1);
        check("ovr_data",  snd_data_out, 8'h22);
        check("ovr_flag",  snd_ovr, 1'b1);
        pulse(0, 1, 0, 0, 8'h00, 8'h00, 1);
        check("ovr_clr",   {snd_pending, snd_ovr}, 2'b00);

        // Same-cycle write and read while pending
        pulse(0, 0, 1, 0, 8'h00, 8'h44, 1);
        pulse(0, 1, 1, 0, 8'h00, 8'h33, 2);
        check("same_pend", snd_pending, 1'b1);
        check("same_ovr",  snd_ovr, 1'b0);
        check("same_data", snd_data_out, 8'h33);
        pulse(0, 1, 0, 0, 8'h00, 8'h00, 1);

        // Long pulse yields a single event
        pulse(0, 0, 1, 0, 8'h00, 8'h77, 6);
        check("long_ovr",  {snd_pending, snd_ovr}, 2'b10);
        pulse(0, 1, 0, 0, 8'h00, 8'h00, 1);

`ifdef SOUND_COMM_FIFO_EN
        // Fill past depth, then drain
        for (int i = 1; i <= 5; i++) pulse(1, 0, 0, 0, 8'(i), 8'h00, 1);
        check("ff_ovr",    main_ovr, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("ff_head", main_data_out, 32'(i));
            pulse(0, 0, 0, 1, 8'h00, 8'h00, 1);
        end
        check("ff_empty",  main_pending, 1'b0);
        check("ff_last",   main_data_out, 8'h04);
        pulse(0, 0, 0, 1, 8'h00, 8'h00, 1);
        check("ff_epop",   {main_pending, main_ovr, main_data_out}, {2'b00, 8'h04});

        // Full FIFO: simultaneous push and pop
        for (int i = 1; i <= 4; i++) pulse(1, 0, 0, 0, 8'(i), 8'h00, 1);
        pulse(1, 0, 0, 1, 8'h09, 8'h00, 1);
        check("ffpp_head", main_data_out, 8'h02);
        check("ffpp_ovr",  main_ovr, 1'b0);
        for (int i = 0; i < 4; i++) pulse(0, 0, 0, 1, 8'h00, 8'h00, 1);
        check("ffpp_last", {main_pending, main_data_out}, {1'b0, 8'h09});

        pulse(1, 0, 0, 0, 8'hC1, 8'h00, 1);
        pulse(1, 0, 0, 0, 8'hC2, 8'h00, 1);
`else
        // Sound-to-main latch direction
        pulse(1, 0, 0, 0, 8'hA5, 8'h00, 1);
        check("sm_data",   {main_pending, main_data_out}, {1'b1, 8'hA5});
        pulse(1, 0, 0, 0, 8'h3C, 8'h00, 2);
        check("sm_ovr",    {main_ovr, main_data_out}, {1'b1, 8'h3C});
        pulse(0, 0, 0, 1, 8'h00, 8'h00, 1);
        check("sm_clr",    {main_pending, main_ovr}, 2'b00);
        pulse(1, 0, 0, 0, 8'hC1, 8'h00, 1);
`endif
        check("pre_rst_pend", main_pending, 1'b1);

        // Reset with WR68k_l held low, then released afterwards
        WR68k_l = 1'b0;
        pulse(0, 0, 1, 0, 8'h00, 8'h66, 1);
        WR68k_l = 1'b0;
        step(1);
        rst_l = 1'b0;
        #1;
        check("ar_flags", {snd_pending, main_pending, snd_ovr, main_ovr}, 4'b0000);
        check("ar_irq",   {snd_irq_l, main_irq_l}, 2'b11);
        check("ar_data",  {snd_data_out, main_data_out}, 16'h0000);
        step(2);
        rst_l = 1'b1;
        step(3);
        WR68k_l = 1'b1;
        step(3);
        check("ar_nopush", main_pending, 1'b0);
        pulse(1, 0, 0, 0, 8'hD7, 8'h00, 1);
        check("ar_push",  {main_pending, main_data_out}, {1'b1, 8'hD7});
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
